// File: rtl/digital_clock.sv
// digital_clock: 24-hour BCD time-of-day counter.
// A prescaler divides master_clk down to a one-second tick, and the tick
// ripples through the seconds, minutes and hours BCD digit pairs.
module digital_clock #(
    parameter int unsigned CLK_DIV = 50_000_000
) (
    input  logic       master_clk,
    input  logic       reset,
    output logic [2:0] seconds_p1,
    output logic [3:0] seconds_p2,
    output logic [2:0] minutes_p1,
    output logic [3:0] minutes_p2,
    output logic [1:0] hours_p1,
    output logic [3:0] hours_p2
);

    // CLK_DIV = 1 still needs a 1-bit prescaler; it simply stays at 0 and
    // ticks on every edge.
    localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [2:0]    sec1_q, sec1_d;
    logic [3:0]    sec2_q, sec2_d;
    logic [2:0]    min1_q, min1_d;
    logic [3:0]    min2_q, min2_d;
    logic [1:0]    hr1_q, hr1_d;
    logic [3:0]    hr2_q, hr2_d;
    logic          tick;
    logic          min_carry;
    logic          hr_carry;

    // Next-state: prescaler wrap produces the tick; carries ripple upward.
    // Digits at or above their top value wrap to 0, so an out-of-range value
    // can never survive a carry into it.
    always_comb begin
        tick      = (presc_q == PRESC_LAST);
        presc_d   = tick ? '0 : presc_q + 1'b1;
        sec1_d    = sec1_q;
        sec2_d    = sec2_q;
        min1_d    = min1_q;
        min2_d    = min2_q;
        hr1_d     = hr1_q;
        hr2_d     = hr2_q;
        min_carry = 1'b0;
        hr_carry  = 1'b0;

        if (tick) begin
            if (sec2_q >= 4'd9) begin
                sec2_d = 4'd0;
                if (sec1_q >= 3'd5) begin
                    sec1_d    = 3'd0;
                    min_carry = 1'b1;
                end else begin
                    sec1_d = sec1_q + 3'd1;
                end
            end else begin
                sec2_d = sec2_q + 4'd1;
            end
        end

        if (min_carry) begin
            if (min2_q >= 4'd9) begin
                min2_d = 4'd0;
                if (min1_q >= 3'd5) begin
                    min1_d   = 3'd0;
                    hr_carry = 1'b1;
                end else begin
                    min1_d = min1_q + 3'd1;
                end
            end else begin
                min2_d = min2_q + 4'd1;
            end
        end

        if (hr_carry) begin
            if ((hr1_q >= 2'd2) && (hr2_q >= 4'd3)) begin
                // 23 -> 00 day wrap
                hr1_d = 2'd0;
                hr2_d = 4'd0;
            end else if (hr2_q >= 4'd9) begin
                hr2_d = 4'd0;
                hr1_d = (hr1_q >= 2'd2) ? 2'd0 : hr1_q + 2'd1;
            end else begin
                hr2_d = hr2_q + 4'd1;
                if (hr1_q > 2'd2) begin
                    hr1_d = 2'd0;
                end
            end
        end
    end

    // State registers; reset clears the time and any partial prescaler count
    // and wins over a coincident tick.
    always_ff @(posedge master_clk) begin
        if (!reset) begin
            presc_q <= '0;
            sec1_q  <= '0;
            sec2_q  <= '0;
            min1_q  <= '0;
            min2_q  <= '0;
            hr1_q   <= '0;
            hr2_q   <= '0;
        end else begin
            presc_q <= presc_d;
            sec1_q  <= sec1_d;
            sec2_q  <= sec2_d;
            min1_q  <= min1_d;
            min2_q  <= min2_d;
            hr1_q   <= hr1_d;
            hr2_q   <= hr2_d;
        end
    end

    assign seconds_p1 = sec1_q;
    assign seconds_p2 = sec2_q;
    assign minutes_p1 = min1_q;
    assign minutes_p2 = min2_q;
    assign hours_p1   = hr1_q;
    assign hours_p2   = hr2_q;

endmodule

// File: tb/tb_digital_clock.sv
// tb_digital_clock: two instances (CLK_DIV = 4 and CLK_DIV = 1) exercised in
// parallel against fixed vector tables, hand sequences and a reference model
// that derives the expected time from edges-since-reset with plain arithmetic.
module tb_digital_clock;

    logic clk = 1'b0;
    logic rst4;
    logic rst1;

    logic [2:0] s1_4, m1_4, s1_1, m1_1;
    logic [3:0] s2_4, m2_4, h2_4, s2_1, m2_1, h2_1;
    logic [1:0] h1_4, h1_1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int edges;
        int hh;
        int mm;
        int ss;
    } vec_t;

    always #5 clk = ~clk;

    digital_clock #(.CLK_DIV(4)) dut4 (
        .master_clk(clk),
        .reset     (rst4),
        .seconds_p1(s1_4),
        .seconds_p2(s2_4),
        .minutes_p1(m1_4),
        .minutes_p2(m2_4),
        .hours_p1  (h1_4),
        .hours_p2  (h2_4)
    );

    digital_clock #(.CLK_DIV(1)) dut1 (
        .master_clk(clk),
        .reset     (rst1),
        .seconds_p1(s1_1),
        .seconds_p2(s2_1),
        .minutes_p1(m1_1),
        .minutes_p2(m2_1),
        .hours_p1  (h1_1),
        .hours_p2  (h2_1)
    );

    function automatic logic [19:0] pack(input int h, input int m, input int s);
        return {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10)};
    endfunction

    function automatic logic [19:0] act4();
        return {h1_4, h2_4, m1_4, m2_4, s1_4, s2_4};
    endfunction

    function automatic logic [19:0] act1();
        return {h1_1, h2_1, m1_1, m2_1, s1_1, s2_1};
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string nm, input logic [19:0] act, input int h, input int m, input int s);
        logic [19:0] exp;
        exp = pack(h, m, s);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d%0d:%0d%0d:%0d%0d want %02d:%02d:%02d", nm,
                     act[19:18], act[17:14], act[13:11], act[10:7], act[6:4], act[3:0], h, m, s);
        end
    endtask

    task automatic check_secs(input string nm, input logic [19:0] act, input int total);
        int t;
        t = total % 86400;
        check(nm, act, t / 3600, (t / 60) % 60, t % 60);
    endtask

    // CLK_DIV = 4 instance: reset, carry table, reset corner cases, random resets
    task automatic run_div4();
        vec_t tbl[6];
        int   e;
        int   r;
        tbl[0] = '{3, 0, 0, 0};
        tbl[1] = '{4, 0, 0, 1};
        tbl[2] = '{36, 0, 0, 9};
        tbl[3] = '{40, 0, 0, 10};
        tbl[4] = '{240, 0, 1, 0};
        tbl[5] = '{14400, 1, 0, 0};

        rst4 = 1'b0;
        step();
        step();
        check("d4_reset_hold", act4(), 0, 0, 0);

        rst4 = 1'b1;
        e = 0;
        for (int i = 0; i < 6; i++) begin
            while (e < tbl[i].edges) begin
                step();
                e++;
            end
            check($sformatf("d4_tbl_%0d", tbl[i].edges), act4(), tbl[i].hh, tbl[i].mm, tbl[i].ss);
        end

        // reset in the middle of a second: 00:00:07 with prescaler at 2
        rst4 = 1'b0;
        step();
        rst4 = 1'b1;
        for (int i = 0; i < 30; i++) step();
        check("d4_pre_mid", act4(), 0, 0, 7);
        rst4 = 1'b0;
        step();
        check("d4_mid_rst", act4(), 0, 0, 0);
        rst4 = 1'b1;
        for (int i = 0; i < 3; i++) step();
        check("d4_mid_3edges", act4(), 0, 0, 0);
        step();
        check("d4_mid_4edges", act4(), 0, 0, 1);

        // reset landing on the very edge that would tick
        for (int i = 0; i < 3; i++) step();
        rst4 = 1'b0;
        step();
        check("d4_rst_prio", act4(), 0, 0, 0);
        rst4 = 1'b1;
        for (int i = 0; i < 4; i++) step();
        check("d4_after_prio", act4(), 0, 0, 1);

        // random reset pulses against the edges-since-release model
        rst4 = 1'b0;
        step();
        e = 0;
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 99) < 3) ? 0 : 1;
            rst4 = r[0];
            step();
            if (r == 0) e = 0;
            else e++;
            check_secs("d4_rand", act4(), e / 4);
        end
        rst4 = 1'b1;
    endtask

    // CLK_DIV = 1 instance: full day run, every edge against the model
    task automatic run_div1();
        vec_t tbl[8];
        int   j;
        tbl[0] = '{1, 0, 0, 1};
        tbl[1] = '{60, 0, 1, 0};
        tbl[2] = '{35999, 9, 59, 59};
        tbl[3] = '{36000, 10, 0, 0};
        tbl[4] = '{71999, 19, 59, 59};
        tbl[5] = '{72000, 20, 0, 0};
        tbl[6] = '{86399, 23, 59, 59};
        tbl[7] = '{86400, 0, 0, 0};

        rst1 = 1'b0;
        step();
        check("d1_reset", act1(), 0, 0, 0);
        rst1 = 1'b1;
        j = 0;
        for (int e = 1; e <= 86401; e++) begin
            step();
            check_secs("d1_run", act1(), e);
            if (j < 8 && e == tbl[j].edges) begin
                check($sformatf("d1_tbl_%0d", tbl[j].edges), act1(), tbl[j].hh, tbl[j].mm, tbl[j].ss);
                j++;
            end
        end
    endtask

    initial begin
        rst4 = 1'b0;
        rst1 = 1'b0;
        fork
            run_div4();
            run_div1();
        join
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
        $fatal(1, "time limit");
    end

endmodule
